// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: the bus bundle around mem_arbiter.
//   core_* : core datapath requester (req/write/addr/wrbits/wdata in, ack/rdata out)
//   host_* : host/debug loader requester (same shape as core_*)
//   mem_*  : single memory macro port (addr/read/write/wrbits/wdata out, rdata in)
// The slave modport is the arbiter's view. The master modport is the
// requesters' and memory model's view.
interface mem_arbiter_if;
    logic        core_req;
    logic        core_write;
    logic [31:0] core_addr;
    logic [3:0]  core_wrbits;
    logic [31:0] core_wdata;
    logic        core_ack;
    logic [31:0] core_rdata;

    logic        host_req;
    logic        host_write;
    logic [31:0] host_addr;
    logic [3:0]  host_wrbits;
    logic [31:0] host_wdata;
    logic        host_ack;
    logic [31:0] host_rdata;

    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_wrbits;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  core_req, core_write, core_addr, core_wrbits, core_wdata,
        output core_ack, core_rdata,
        input  host_req, host_write, host_addr, host_wrbits, host_wdata,
        output host_ack, host_rdata,
        output mem_addr, mem_read, mem_write, mem_wrbits, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_write, core_addr, core_wrbits, core_wdata,
        input  core_ack, core_rdata,
        output host_req, host_write, host_addr, host_wrbits, host_wdata,
        input  host_ack, host_rdata,
        input  mem_addr, mem_read, mem_write, mem_wrbits, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the core and the host loader.
// Only one transaction is in flight at a time. A granted transaction drives
// the memory for MEM_LAT cycles. It then returns a single ack pulse, carrying
// read data, to the requester that won.
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : mem_arbiter_if.slave (core_*, host_*, mem_* signals)
// Parameters:
//   MEM_LAT   : number of access cycles, 1..7
//   HOST_PRIO : 1 lets the host win the first conflict after reset, 0 lets the core win it
module mem_arbiter #(
    parameter int MEM_LAT   = 1,
    parameter bit HOST_PRIO = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    generate
        if ((MEM_LAT < 1) || (MEM_LAT > 7)) begin : g_bad_lat
            $error("mem_arbiter: MEM_LAT must be in 1..7");
        end
    endgenerate

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [3:0]  wrbits;
        logic [31:0] wdata;
    } txn_t;

    state_t      state, state_nxt;
    txn_t        txn;            // latched copy of the granted request
    logic [2:0]  lat_cnt;        // ACCESS cycles left, including the current one
    logic        own_host;       // owner of the transaction in flight
    logic        last_host;      // most recent grant, used for round-robin
    logic [31:0] core_rdata_q, host_rdata_q;

    logic grant, grant_host;
    logic first_cyc, last_cyc;
    logic mem_read_c, mem_write_c;
    logic core_ack_c, host_ack_c;

    assign first_cyc = (lat_cnt == LAT);
    assign last_cyc  = (lat_cnt == 3'd1);

    // The host wins when it is the only requester. It also wins a conflict
    // whenever the previous grant went to the core.
    assign grant_host = bus.host_req && (!bus.core_req || !last_host);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        grant       = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        core_ack_c  = 1'b0;
        host_ack_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.core_req || bus.host_req) begin
                    grant     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                // A read holds mem_read for the whole window.
                // A write strobes only in the first cycle.
                mem_read_c  = !txn.write;
                mem_write_c = txn.write && first_cyc;
                if (last_cyc) state_nxt = ACK;
            end
            ACK: begin
                core_ack_c = !own_host;
                host_ack_c = own_host;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            txn          <= '0;
            lat_cnt      <= 3'd0;
            own_host     <= 1'b0;
            last_host    <= ~HOST_PRIO;
            core_rdata_q <= 32'd0;
            host_rdata_q <= 32'd0;
        end else if (grant) begin
            own_host  <= grant_host;
            last_host <= grant_host;
            lat_cnt   <= LAT;
            if (grant_host) txn <= '{bus.host_write, bus.host_addr, bus.host_wrbits, bus.host_wdata};
            else            txn <= '{bus.core_write, bus.core_addr, bus.core_wrbits, bus.core_wdata};
        end else if (state == ACCESS) begin
            lat_cnt <= lat_cnt - 3'd1;
            // A read returns data on the edge that ends the access window.
            // A write leaves both rdata registers untouched.
            if (last_cyc && !txn.write) begin
                if (own_host) host_rdata_q <= bus.mem_rdata;
                else          core_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // mem_addr and mem_wdata follow the latched request. They therefore
    // keep their last values while the arbiter sits in IDLE.
    assign bus.mem_addr   = txn.addr;
    assign bus.mem_wdata  = txn.wdata;
    assign bus.mem_read   = mem_read_c;
    assign bus.mem_write  = mem_write_c;
    assign bus.mem_wrbits = mem_write_c ? txn.wrbits : 4'd0;
    assign bus.core_ack   = core_ack_c;
    assign bus.host_ack   = host_ack_c;
    assign bus.core_rdata = core_rdata_q;
    assign bus.host_rdata = host_rdata_q;

endmodule
